vending_machine: RTL and testbench



---
 rtl/vending_machine.sv | 52 +++++
 tb/tb_vending_machine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// vending_machine: coin-accepting vending controller that pulses valid for one cycle per sale
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   coin  - coin code per edge: 00 none, 01 nickel, 10 dime, 11 invalid (treated as none)
//   valid - registered dispense pulse, high for exactly one cycle per sale
module vending_machine #(
   parameter int NICKEL_VALUE = 1,
   parameter int DIME_VALUE   = 2,
   parameter int PRICE        = 4,
   parameter int CREDIT_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] coin,
   output logic       valid
);
   typedef enum logic [1:0] {IDLE = 2'b00, ACCUM = 2'b01, OK = 2'b10} state_t;
   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic                r_valid;
   logic [CREDIT_W:0]   w_add;
   logic [CREDIT_W:0]   w_sum;
   logic                w_live;
   // one extra bit on the sum so credit + dime can never wrap before the compare
   always_comb begin
      w_add  = (coin == 2'b01) ? (CREDIT_W+1)'(NICKEL_VALUE) :
               (coin == 2'b10) ? (CREDIT_W+1)'(DIME_VALUE) : '0;
      w_sum  = {1'b0, r_credit} + w_add;
      w_live = (r_state == IDLE) || (r_state == ACCUM);
   end
   // OK and the unused encoding both fall through to IDLE; the coin seen in OK is dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_credit <= '0;
         r_valid  <= 1'b0;
      end else if (w_live && w_sum >= (CREDIT_W+1)'(PRICE)) begin
         r_state  <= OK;
         r_credit <= '0;
         r_valid  <= 1'b1;
      end else if (w_live && w_sum != '0) begin
         r_state  <= ACCUM;
         r_credit <= w_sum[CREDIT_W-1:0];
         r_valid  <= 1'b0;
      end else begin
         r_state  <= IDLE;
         r_credit <= '0;
         r_valid  <= 1'b0;
      end
   end
   assign valid = r_valid;
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed and randomized checks of vending_machine against a cents-based model
module tb_vending_machine;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       valid;
   int n_vec = 0;
   int n_err = 0;
   int m_cents = 0;
   bit m_sale = 1'b0;

   vending_machine dut (.clk(clk), .reset(reset), .coin(coin), .valid(valid));

   always #5 clk = ~clk;

   // model: credit in cents, a sale happens at 20 cents, the cycle after a sale swallows its coin
   task automatic model_edge(input logic [1:0] c);
      if (!reset) begin
         m_cents = 0;
         m_sale  = 1'b0;
      end else if (m_sale) begin
         m_cents = 0;
         m_sale  = 1'b0;
      end else begin
         m_cents = m_cents + ((c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0);
         if (m_cents >= 20) begin
            m_cents = 0;
            m_sale  = 1'b1;
         end
      end
   endtask

   task automatic drive(input logic [1:0] c);
      coin = c;
      @(posedge clk);
      #1;
      model_edge(c);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #3;
      reset = 1'b1;
      m_cents = 0;
      m_sale  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      coin  = 2'b01;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: valid=%b expected 0", i, valid);
         end
      end
      reset = 1'b1;
      m_cents = 0;
      m_sale  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(i < 4 ? 2'b01 : 2'b00);
         n_vec++;
         if (valid !== (i == 3)) begin
            n_err++;
            $display("FAIL reset_release edge %0d: valid=%b expected %b", i + 1, valid, i == 3);
         end
      end
   endtask

   task automatic test_nickel_stream();
      bit exp [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         drive(2'b01);
         n_vec++;
         if (valid !== exp[i]) begin
            n_err++;
            $display("FAIL nickel_stream edge %0d: valid=%b expected %b", i + 1, valid, exp[i]);
         end
      end
   endtask

   task automatic test_dimes_overpay();
      logic [1:0] seq [11] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
      bit         exp [11] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      pulse_reset();
      for (int i = 0; i < 11; i++) begin
         drive(seq[i]);
         n_vec++;
         if (valid !== exp[i]) begin
            n_err++;
            $display("FAIL dimes_overpay edge %0d: valid=%b expected %b", i + 1, valid, exp[i]);
         end
      end
      drive(2'b01);
      n_vec++;
      if (valid !== 1'b1) begin
         n_err++;
         $display("FAIL dimes_next_sale: valid=%b expected 1", valid);
      end
   endtask

   task automatic test_invalid_codes();
      logic [1:0] seq [8] = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 2'b11};
      bit         exp [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         drive(seq[i]);
         n_vec++;
         if (valid !== exp[i]) begin
            n_err++;
            $display("FAIL invalid_codes edge %0d: valid=%b expected %b", i + 1, valid, exp[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      pulse_reset();
      drive(2'b01);
      drive(2'b01);
      pulse_reset();
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_valid: valid=%b expected 0", valid);
      end
      for (int i = 0; i < 5; i++) begin
         drive(i < 4 ? 2'b01 : 2'b00);
         n_vec++;
         if (valid !== (i == 3)) begin
            n_err++;
            $display("FAIL mid_reset edge %0d: valid=%b expected %b", i + 1, valid, i == 3);
         end
      end
   endtask

   task automatic test_ok_coin();
      logic [1:0] seq [7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
      bit         exp [7] = '{0, 1, 0, 0, 0, 0, 1};
      pulse_reset();
      for (int i = 0; i < 7; i++) begin
         drive(seq[i]);
         n_vec++;
         if (valid !== exp[i]) begin
            n_err++;
            $display("FAIL ok_coin edge %0d: valid=%b expected %b", i + 1, valid, exp[i]);
         end
      end
   endtask

   task automatic test_async_drop();
      pulse_reset();
      drive(2'b10);
      drive(2'b10);
      n_vec++;
      if (valid !== 1'b1) begin
         n_err++;
         $display("FAIL async_setup: valid=%b expected 1", valid);
      end
      reset = 1'b0;
      #1;
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_drop: valid=%b expected 0", valid);
      end
      #2;
      reset = 1'b1;
      m_cents = 0;
      m_sale  = 1'b0;
      drive(2'b00);
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_after: valid=%b expected 0", valid);
      end
   endtask

   task automatic test_random();
      pulse_reset();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 39) != 0);
         drive(2'($urandom_range(0, 3)));
         n_vec++;
         if (valid !== m_sale) begin
            n_err++;
            $display("FAIL random step %0d: valid=%b expected %b (credit %0d cents)", i, valid, m_sale, m_cents);
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      #2;
      test_reset();
      test_nickel_stream();
      test_dimes_overpay();
      test_invalid_codes();
      test_mid_reset();
      test_ok_coin();
      test_async_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
